// File: rtl/mult_div_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
// Op codes, FSM states and iteration sizing live here.
package mult_div_pkg;

  localparam int MD_ITER  = 32;
  localparam int MD_CNT_W = $clog2(MD_ITER);

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } md_state_t;

  // 0x80000000 comes back unchanged and is read as unsigned 2^31
  function automatic logic [31:0] md_mag(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mult_div_step.sv
// One combinational iteration: shift-add for multiply,
// restoring shift-subtract for divide.
module mult_div_step #(
  parameter int W = 32
) (
  input  logic         i_div,
  input  logic [W-1:0] i_acc,
  input  logic [W-1:0] i_q,
  input  logic [W-1:0] i_m,
  output logic [W-1:0] o_acc,
  output logic [W-1:0] o_q
);

  logic [W:0] w_sum;
  logic [W:0] w_sh;
  logic       w_ge;

  always_comb begin
    w_sum = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_m} : '0);
    w_sh  = {i_acc, i_q[W-1]};
    w_ge  = (w_sh >= {1'b0, i_m});
    o_acc = '0;
    o_q   = '0;
    if (i_div) begin
      // result of a successful trial is below i_m, so W bits suffice
      o_acc = w_ge ? (w_sh[W-1:0] - i_m) : w_sh[W-1:0];
      o_q   = {i_q[W-2:0], w_ge};
    end else begin
      o_acc = w_sum[W:1];
      o_q   = {w_sum[0], i_q[W-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO.
// Magnitude datapath in RUN, sign fixup in FIX.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ITER       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [1:0]            MDOperation,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  HIWrite,
  input  logic                  LOWrite,
  output logic                  Busy,
  output logic                  Done,
  output logic                  DivByZero,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  md_state_t r_state;
  md_state_t w_next;

  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_q;
  logic [DATA_WIDTH-1:0] r_m;
  logic [DATA_WIDTH-1:0] r_a;
  logic                  r_div;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic                  r_dz;
  logic                  r_done;
  logic                  r_dz_flag;
  logic [DATA_WIDTH-1:0] r_hi;
  logic [DATA_WIDTH-1:0] r_lo;

  logic                  w_signed;
  logic                  w_isdiv;
  logic [DATA_WIDTH-1:0] w_mag_a;
  logic [DATA_WIDTH-1:0] w_mag_b;
  logic [DATA_WIDTH-1:0] w_acc;
  logic [DATA_WIDTH-1:0] w_q;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0] w_hi;
  logic [DATA_WIDTH-1:0] w_lo;

  assign w_signed = ~MDOperation[0];
  assign w_isdiv  = MDOperation[1];
  assign w_mag_a  = md_mag(A, w_signed);
  assign w_mag_b  = md_mag(B, w_signed);

  mult_div_step #(
    .W(DATA_WIDTH)
  ) u_step (
    .i_div (r_div),
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_m   (r_m),
    .o_acc (w_acc),
    .o_q   (w_q)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (Start) w_next = S_RUN;
      S_RUN:   if (r_cnt == LAST) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_prod = {r_acc, r_q};
    if (r_neg_q) w_prod = '0 - w_prod;
    w_hi = '0;
    w_lo = '0;
    if (!r_div) begin
      w_hi = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
      w_lo = w_prod[DATA_WIDTH-1:0];
    end else if (r_dz) begin
      w_hi = r_a;
      w_lo = '1;
    end else begin
      w_hi = r_neg_r ? ('0 - r_acc) : r_acc;
      w_lo = r_neg_q ? ('0 - r_q) : r_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_a       <= '0;
      r_div     <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz      <= 1'b0;
      r_done    <= 1'b0;
      r_dz_flag <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_div     <= w_isdiv;
            r_a       <= A;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_q       <= w_isdiv ? w_mag_a : w_mag_b;
            r_m       <= w_isdiv ? w_mag_b : w_mag_a;
            r_neg_q   <= w_signed & (A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1]);
            r_neg_r   <= w_signed & A[DATA_WIDTH-1];
            r_dz      <= w_isdiv & (B == '0);
            r_dz_flag <= 1'b0;
          end else begin
            if (HIWrite) r_hi <= A;
            if (LOWrite) r_lo <= A;
          end
        end
        S_RUN: begin
          r_acc <= w_acc;
          r_q   <= w_q;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_hi      <= w_hi;
          r_lo      <= w_lo;
          r_done    <= 1'b1;
          r_dz_flag <= r_dz;
        end
        default: ;
      endcase
    end
  end

  assign Busy      = (r_state != S_IDLE);
  assign Done      = r_done;
  assign DivByZero = r_dz_flag;
  assign HI        = r_hi;
  assign LO        = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with a
// 64-bit arithmetic reference for random operands.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  MDOperation;
  logic [31:0] A;
  logic [31:0] B;
  logic        HIWrite;
  logic        LOWrite;
  logic        Busy;
  logic        Done;
  logic        DivByZero;
  logic [31:0] HI;
  logic [31:0] LO;

  int tests = 0;
  int fails = 0;

  mult_div_unit dut (
    .clk         (clk),
    .reset       (reset),
    .Start       (Start),
    .MDOperation (MDOperation),
    .A           (A),
    .B           (B),
    .HIWrite     (HIWrite),
    .LOWrite     (LOWrite),
    .Busy        (Busy),
    .Done        (Done),
    .DivByZero   (DivByZero),
    .HI          (HI),
    .LO          (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch from a negedge, return at the negedge of the Done cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output logic dz, output int lat,
                        output int busyc, output logic dzc);
    MDOperation = op;
    A = a;
    B = b;
    Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    lat = -1;
    busyc = 0;
    hi = 'x;
    lo = 'x;
    dz = 1'bx;
    dzc = 1'bx;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) dzc = DivByZero;
      if (Busy) busyc++;
      if (Done) begin
        lat = k;
        hi = HI;
        lo = LO;
        dz = DivByZero;
        break;
      end
    end
  endtask

  function automatic void model(input logic [1:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] hi,
                                output logic [31:0] lo,
                                output logic dz);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    dz = 1'b0;
    p = '0;
    case (op)
      2'b00: p = sa * sb;
      2'b01: p = {32'd0, a} * {32'd0, b};
      default: p = '0;
    endcase
    hi = p[63:32];
    lo = p[31:0];
    if (op[1]) begin
      if (b == 0) begin
        hi = a;
        lo = 32'hFFFFFFFF;
        dz = 1'b1;
      end else if (op == 2'b10) begin
        sq = sa / sb;
        sr = sa % sb;
        lo = sq[31:0];
        hi = sr[31:0];
      end else begin
        lo = a / b;
        hi = a % b;
      end
    end
  endfunction

  logic [31:0] r_hi, r_lo, m_hi, m_lo;
  logic        r_dz, r_dzc, m_dz;
  int          lat, busyc, ndone;
  string       nm;

  initial begin
    vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0};
    vecs[5]  = '{2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0, 1'b0};
    vecs[7]  = '{2'b00, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000, 1'b0};
    vecs[8]  = '{2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3, 1'b0};
    vecs[10] = '{2'b01, 32'h12345678, 32'h10, 32'd1, 32'h23456780, 1'b0};
    vecs[11] = '{2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    vecs[12] = '{2'b11, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0};
    vecs[13] = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
    vecs[14] = '{2'b00, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0};

    reset = 1'b1;
    Start = 1'b0;
    MDOperation = 2'b00;
    A = '0;
    B = '0;
    HIWrite = 1'b0;
    LOWrite = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_dz", 64'(DivByZero), 64'd0);
    chk("rst_hi", 64'(HI), 64'd0);
    chk("rst_lo", 64'(LO), 64'd0);

    // idle MTHI+MTLO, then MTHI alone
    A = 32'hCAFE;
    HIWrite = 1'b1;
    LOWrite = 1'b1;
    @(posedge clk);
    #1 HIWrite = 1'b0;
    LOWrite = 1'b0;
    @(negedge clk);
    chk("mthilo_hi", 64'(HI), 64'hCAFE);
    chk("mthilo_lo", 64'(LO), 64'hCAFE);
    A = 32'h1234;
    HIWrite = 1'b1;
    @(posedge clk);
    #1 HIWrite = 1'b0;
    @(negedge clk);
    chk("mthi_hi", 64'(HI), 64'h1234);
    chk("mthi_lo", 64'(LO), 64'hCAFE);

    // reset mid-RUN
    MDOperation = 2'b01;
    A = 32'hFFFFFFFF;
    B = 32'hFFFFFFFF;
    Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (Done) ndone++;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(Busy), 64'd0);
    chk("midrst_hi", 64'(HI), 64'd0);
    chk("midrst_lo", 64'(LO), 64'd0);
    reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (Done) ndone++;
    end
    chk("midrst_nodone", 64'(ndone), 64'd0);

    // table, issued back-to-back in each Done cycle
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r_hi, r_lo, r_dz,
             lat, busyc, r_dzc);
      nm = $sformatf("vec%0d", i);
      chk({nm, "_hi"}, 64'(r_hi), 64'(vecs[i].hi));
      chk({nm, "_lo"}, 64'(r_lo), 64'(vecs[i].lo));
      chk({nm, "_dz"}, 64'(r_dz), 64'(vecs[i].dz));
      chk({nm, "_lat"}, 64'(lat), 64'd34);
      chk({nm, "_busy"}, 64'(busyc), 64'd33);
      chk({nm, "_dzclr"}, 64'(r_dzc), 64'd0);
    end

    // Start + HIWrite at cycle 5 of a running op are ignored
    MDOperation = 2'b01;
    A = 32'd3;
    B = 32'd5;
    Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 5) begin
        Start = 1'b1;
        HIWrite = 1'b1;
        MDOperation = 2'b10;
        A = 32'h1234;
      end else if (k == 6) begin
        Start = 1'b0;
        HIWrite = 1'b0;
      end
      if (Done) begin
        lat = k;
        break;
      end
    end
    chk("busyign_lat", 64'(lat), 64'd34);
    chk("busyign_hi", 64'(HI), 64'd0);
    chk("busyign_lo", 64'(LO), 64'd15);
    @(negedge clk);
    chk("busyign_noq", 64'(Busy), 64'd0);

    // idle MTHI after an op
    A = 32'h1234;
    HIWrite = 1'b1;
    @(posedge clk);
    #1 HIWrite = 1'b0;
    @(negedge clk);
    chk("mthi2_hi", 64'(HI), 64'h1234);
    chk("mthi2_lo", 64'(LO), 64'd15);

    // Start with HIWrite/LOWrite in IDLE: writes dropped
    HIWrite = 1'b1;
    LOWrite = 1'b1;
    run_op(2'b01, 32'd2, 32'd3, r_hi, r_lo, r_dz, lat, busyc, r_dzc);
    HIWrite = 1'b0;
    LOWrite = 1'b0;
    chk("startwin_hi", 64'(r_hi), 64'd0);
    chk("startwin_lo", 64'(r_lo), 64'd6);

    // back-to-back pair
    run_op(2'b11, 32'd9, 32'd0, r_hi, r_lo, r_dz, lat, busyc, r_dzc);
    chk("b2b0_dz", 64'(r_dz), 64'd1);
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, r_hi, r_lo, r_dz,
           lat, busyc, r_dzc);
    chk("b2b1_lat", 64'(lat), 64'd34);
    chk("b2b1_res", {r_hi, r_lo}, 64'd1);
    chk("b2b1_dzclr", 64'(r_dzc), 64'd0);

    // random operands against the 64-bit reference
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (i % 6 == 5) b = 32'd0;
      else if (i % 6 == 4) b = 32'($urandom_range(1, 9));
      model(op, a, b, m_hi, m_lo, m_dz);
      run_op(op, a, b, r_hi, r_lo, r_dz, lat, busyc, r_dzc);
      nm = $sformatf("rnd%0d_op%0d_%h_%h", i, op, a, b);
      chk({nm, "_res"}, {r_hi, r_lo}, {m_hi, m_lo});
      chk({nm, "_dz"}, 64'(r_dz), 64'(m_dz));
      chk({nm, "_lat"}, 64'(lat), 64'd34);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
